frame_write_arbiter: RTL and testbench
======================================

# frame_write_arbiter

Frame-synchronous write arbiter for the double-buffered 1-bit frame buffer. It shares the frame buffer write port between up to N_REQ pixel writers, such as the game renderer and test-pattern generators, in the renderer clock domain. Writing is confined to the window between two `swap` pulses. Requesters get round-robin, burst-limited grants, and the block reports frame completion and overruns. It replaces the static per-switch write mux: the per-frame `enable` mask selects which writers participate.

## Interface

Parameters:
- N_REQ, 2: number of write requesters (≥1).
- PIXEL_ADDR_WIDTH, 19: frame buffer address width (640×480).
- MAX_BURST, 64: maximum accepted writes per grant (≥1).

Ports:
- clk, in, 1: renderer clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- ce, in, 1: clock enable; low freezes all state.
- swap, in, 1: one-cycle pulse, frame buffer swapped; already synchronous to clk.
- enable, in, N_REQ: requester participation mask; sampled in START.
- req, in, N_REQ: requester i wants the port.
- done, in, N_REQ: level; requester i has finished its frame.
- wr_en_in, in, N_REQ: write strobe from requester i.
- wr_addr_in, in, N_REQ*PIXEL_ADDR_WIDTH: slice i is the address of requester i.
- wr_data_in, in, N_REQ: pixel bit of requester i.
- grant, out, N_REQ: one-hot or zero; requester i may write.
- wr_en, out, 1: frame buffer write enable.
- wr_addr, out, PIXEL_ADDR_WIDTH: frame buffer write address.
- wr_data, out, 1: frame buffer write data.
- frame_start, out, 1: one-cycle pulse at the start of each write window.
- frame_done, out, 1: level; all enabled requesters are done.
- overrun, out, 1: one-cycle pulse when `swap` arrives before frame_done.
- overrun_count, out, 8: saturating count of overruns since reset.

## Operation

- All state and outputs are registered. Every register updates only when ce=1, except wr_en, which is forced 0 on any cycle after ce=0.
- The state machine has five states: WAIT_SWAP, START, ARB, GRANT, DONE.
  - WAIT_SWAP: the reset state; no grants are issued. On `swap` the FSM moves to START.
  - START: lasts one cycle and asserts frame_start. It latches `enable` into en_q and clears the done mask. The next state is ARB.
  - ARB: the done mask is refreshed with done & en_q.
    - If every en_q bit is done (including en_q=0), the FSM goes to DONE.
    - Otherwise it picks the first i with req[i] & en_q[i] & ~done[i]. The search starts at rr_ptr+1 and wraps modulo N_REQ.
    - If a requester is picked, the FSM sets grant[i], rr_ptr=i and burst_cnt=0, then goes to GRANT.
    - If none is picked, it stays in ARB.
  - GRANT: each cycle with wr_en_in[i]=1 is accepted and burst_cnt is incremented. The grant is released (grant=0, next state ARB) when any of these holds:
    - req[i]=0;
    - done[i]=1;
    - the accepted write brings burst_cnt to MAX_BURST.
  - DONE: frame_done=1 and no grants are issued. On `swap` the FSM moves to START.
- Overrun: `swap` in ARB or GRANT drops the grant immediately and pulses overrun. overrun_count increments and saturates at 255. The FSM then goes to START, so the new frame begins normally.
- `swap` in START is ignored.
- wr_en_in from an ungranted requester is ignored; it is never forwarded.
- The output mux forwards only the granted slice. wr_addr and wr_data hold their last values while wr_en=0.
- After a release, re-arbitration always costs one ARB cycle, including re-granting the same requester when it is alone.
- Reset values:
  - State WAIT_SWAP; rr_ptr=N_REQ-1, so requester 0 has first priority.
  - grant=0, wr_en=0, wr_addr=0, wr_data=0.
  - frame_start=0, frame_done=0, overrun=0, overrun_count=0.
- rst during GRANT drops the grant and the pending write on the next edge. rst has priority over ce and swap.

## Timing

- swap high at edge n puts the FSM in START at cycle n+1 (frame_start=1). ARB follows at n+2, and the earliest grant is at n+3.
- grant is registered. A request sampled in ARB at edge k shows grant high from k+1.
- A write is accepted at any edge where grant[i]=1 and wr_en_in[i]=1. wr_en, wr_addr and wr_data appear one cycle later, so the fixed latency is 1.
- Burst end: after the MAX_BURST-th accepted write, grant falls on the next edge. The requester can never exceed MAX_BURST writes per grant.
- Release due to req or done falling: grant falls one cycle after the input is sampled low or high respectively. A write in that same cycle is still accepted.
- Overrun: grant=0 and overrun=1 in the cycle after swap. frame_start follows in that same cycle.

## Test plan

- Reset, then `swap` with enable=01, req0=1 and wr_en_in0 on every cycle, MAX_BURST=4:
  - the first grant0 appears 3 cycles after swap;
  - exactly 4 writes reach wr_en with a 1-cycle delay;
  - there is a 1-cycle gap, then a regrant.
- enable=11 with both requesters continuously requesting: grants alternate 0,1,0,1, each burst is 4 writes, and wr_addr matches the granted slice.
- Requester 0 raises done mid-burst while requester 1 is idle and done=1: grant0 drops and frame_done rises 2 cycles later; a second `swap` gives frame_start and no overrun.
- `swap` during GRANT: overrun pulses once, overrun_count goes 0→1, grant is 0 the next cycle, and frame_start is 1. Repeated 300 times, overrun_count saturates at 255.
- Ungranted wr_en_in1=1 while grant0 is active: the output carries only requester 0's addresses. With enable=00, `swap` leads to frame_done 2 cycles after START.
- ce held low for 10 cycles during GRANT: state and burst_cnt are frozen and wr_en=0. After ce returns, the burst resumes with its remaining count. rst mid-burst clears all outputs on the next edge.

Source files
------------

// File: rtl/frame_write_arbiter.sv
// Frame-synchronous, round-robin, burst-limited arbiter for the shared frame
// buffer write port. Writers may only write between two swap pulses.
module frame_write_arbiter #(
  parameter int N_REQ            = 2,
  parameter int PIXEL_ADDR_WIDTH = 19,
  parameter int MAX_BURST        = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ce,
  input  logic                              swap,
  input  logic [N_REQ-1:0]                  enable,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ-1:0]                  done,
  input  logic [N_REQ-1:0]                  wr_en_in,
  input  logic [N_REQ*PIXEL_ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [N_REQ-1:0]                  wr_data_in,
  output logic [N_REQ-1:0]                  grant,
  output logic                              wr_en,
  output logic [PIXEL_ADDR_WIDTH-1:0]       wr_addr,
  output logic                              wr_data,
  output logic                              frame_start,
  output logic                              frame_done,
  output logic                              overrun,
  output logic [7:0]                        overrun_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    WAIT_SWAP = 3'd0,
    START     = 3'd1,
    ARB       = 3'd2,
    GRANT     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                      state_r, state_nxt_s;
  logic [N_REQ-1:0]            en_q_r, en_q_nxt_s;
  logic [IDX_W-1:0]            rr_ptr_r, rr_ptr_nxt_s;
  logic [CNT_W-1:0]            burst_cnt_r, burst_nxt_s;
  logic [N_REQ-1:0]            grant_r, grant_nxt_s;
  logic                        wr_en_r, wr_en_nxt_s;
  logic [PIXEL_ADDR_WIDTH-1:0] wr_addr_r, wr_addr_nxt_s;
  logic                        wr_data_r, wr_data_nxt_s;
  logic                        frame_start_r, frame_start_nxt_s;
  logic                        frame_done_r, frame_done_nxt_s;
  logic                        overrun_r, overrun_nxt_s;
  logic [7:0]                  overrun_count_r, overrun_count_nxt_s;

  logic [N_REQ-1:0]            done_now_s, eligible_s, pick_onehot_s;
  logic                        all_done_s, pick_valid_s, hit_s;
  logic [IDX_W-1:0]            pick_idx_s;
  int                          dist_s, best_s;
  logic                        sel_req_s, sel_done_s, sel_we_s, sel_data_s;
  logic [PIXEL_ADDR_WIDTH-1:0] sel_addr_s;
  logic                        accept_s, release_s;
  logic [CNT_W-1:0]            burst_inc_s;

  assign grant         = grant_r;
  assign wr_en         = wr_en_r;
  assign wr_addr       = wr_addr_r;
  assign wr_data       = wr_data_r;
  assign frame_start   = frame_start_r;
  assign frame_done    = frame_done_r;
  assign overrun       = overrun_r;
  assign overrun_count = overrun_count_r;

  // Round-robin pick: smallest distance from rr_ptr+1 among eligible requesters
  always_comb begin
    done_now_s   = done & en_q_r;
    all_done_s   = (done_now_s == en_q_r);
    eligible_s   = req & en_q_r & ~done_now_s;
    pick_valid_s = 1'b0;
    pick_idx_s   = rr_ptr_r;
    best_s       = N_REQ;
    dist_s       = 0;
    hit_s        = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      dist_s       = (i + N_REQ - 1 - int'(rr_ptr_r)) % N_REQ;
      hit_s        = eligible_s[i] && (dist_s < best_s);
      best_s       = hit_s ? dist_s : best_s;
      pick_idx_s   = hit_s ? IDX_W'(i) : pick_idx_s;
      pick_valid_s = pick_valid_s | hit_s;
    end
    for (int i = 0; i < N_REQ; i++) begin
      pick_onehot_s[i] = (pick_idx_s == IDX_W'(i));
    end
  end

  // Slice mux for the currently granted requester (rr_ptr holds its index)
  always_comb begin
    sel_req_s  = 1'b0;
    sel_done_s = 1'b0;
    sel_we_s   = 1'b0;
    sel_data_s = 1'b0;
    sel_addr_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_req_s  = (rr_ptr_r == IDX_W'(i)) ? req[i]        : sel_req_s;
      sel_done_s = (rr_ptr_r == IDX_W'(i)) ? done[i]       : sel_done_s;
      sel_we_s   = (rr_ptr_r == IDX_W'(i)) ? wr_en_in[i]   : sel_we_s;
      sel_data_s = (rr_ptr_r == IDX_W'(i)) ? wr_data_in[i] : sel_data_s;
      sel_addr_s = (rr_ptr_r == IDX_W'(i)) ?
                   wr_addr_in[i*PIXEL_ADDR_WIDTH +: PIXEL_ADDR_WIDTH] : sel_addr_s;
    end
    accept_s    = (state_r == GRANT) && sel_we_s;
    burst_inc_s = burst_cnt_r + CNT_ONE;
    release_s   = !sel_req_s || sel_done_s || (accept_s && (burst_inc_s == BURST_MAX));
  end

  // Next-state logic; swap in ARB/GRANT aborts the frame straight into START
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_SWAP: state_nxt_s = swap ? START : WAIT_SWAP;
      START:     state_nxt_s = ARB;
      ARB: begin
        if (swap) begin
          state_nxt_s = START;
        end else if (all_done_s) begin
          state_nxt_s = DONE;
        end else if (pick_valid_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = ARB;
        end
      end
      GRANT: begin
        if (swap) begin
          state_nxt_s = START;
        end else if (release_s) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      DONE:      state_nxt_s = swap ? START : DONE;
      default:   state_nxt_s = WAIT_SWAP;
    endcase
  end

  // Next values of the registered outputs and datapath state
  always_comb begin
    en_q_nxt_s          = en_q_r;
    rr_ptr_nxt_s        = rr_ptr_r;
    burst_nxt_s         = burst_cnt_r;
    grant_nxt_s         = '0;
    wr_en_nxt_s         = 1'b0;
    wr_addr_nxt_s       = wr_addr_r;
    wr_data_nxt_s       = wr_data_r;
    overrun_nxt_s       = swap && ((state_r == ARB) || (state_r == GRANT));
    frame_start_nxt_s   = (state_nxt_s == START);
    frame_done_nxt_s    = (state_nxt_s == DONE);
    overrun_count_nxt_s = (overrun_nxt_s && (overrun_count_r != 8'hFF)) ?
                          overrun_count_r + 8'd1 : overrun_count_r;
    case (state_r)
      START: begin
        en_q_nxt_s = enable;
      end
      ARB: begin
        if (state_nxt_s == GRANT) begin
          rr_ptr_nxt_s = pick_idx_s;
          burst_nxt_s  = '0;
          grant_nxt_s  = pick_onehot_s;
        end else begin
          grant_nxt_s  = '0;
        end
      end
      GRANT: begin
        // A write coinciding with swap belongs to the old frame and is dropped
        if (accept_s && !swap) begin
          burst_nxt_s   = burst_inc_s;
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = sel_addr_s;
          wr_data_nxt_s = sel_data_s;
        end else begin
          burst_nxt_s   = burst_cnt_r;
        end
        grant_nxt_s = (state_nxt_s == GRANT) ? grant_r : '0;
      end
      default: begin
        grant_nxt_s = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_SWAP;
    end else if (ce) begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers; only wr_en moves while ce is low
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q_r          <= '0;
      rr_ptr_r        <= LAST_IDX;
      burst_cnt_r     <= '0;
      grant_r         <= '0;
      wr_en_r         <= 1'b0;
      wr_addr_r       <= '0;
      wr_data_r       <= 1'b0;
      frame_start_r   <= 1'b0;
      frame_done_r    <= 1'b0;
      overrun_r       <= 1'b0;
      overrun_count_r <= 8'd0;
    end else if (ce) begin
      en_q_r          <= en_q_nxt_s;
      rr_ptr_r        <= rr_ptr_nxt_s;
      burst_cnt_r     <= burst_nxt_s;
      grant_r         <= grant_nxt_s;
      wr_en_r         <= wr_en_nxt_s;
      wr_addr_r       <= wr_addr_nxt_s;
      wr_data_r       <= wr_data_nxt_s;
      frame_start_r   <= frame_start_nxt_s;
      frame_done_r    <= frame_done_nxt_s;
      overrun_r       <= overrun_nxt_s;
      overrun_count_r <= overrun_count_nxt_s;
    end else begin
      wr_en_r         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Bench for frame_write_arbiter (N_REQ=2, MAX_BURST=4): cycle table for the
// main frame flow, hand sequences for overrun saturation, ce freeze and reset.
module tb_frame_write_arbiter;
  localparam int N  = 2;
  localparam int AW = 19;
  localparam int MB = 4;
  localparam int NV = 32;

  logic            clk = 1'b0;
  logic            rst, ce, swap;
  logic [N-1:0]    enable, req, done, wr_en_in, wr_data_in;
  logic [N*AW-1:0] wr_addr_in;
  logic [N-1:0]    grant;
  logic            wr_en, wr_data, frame_start, frame_done, overrun;
  logic [AW-1:0]   wr_addr;
  logic [7:0]      overrun_count;

  frame_write_arbiter #(.N_REQ(N), .PIXEL_ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .ce(ce), .swap(swap), .enable(enable), .req(req),
    .done(done), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .grant(grant), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_start(frame_start), .frame_done(frame_done),
    .overrun(overrun), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sw;
    logic [1:0] en, rq, dn, we;
    logic [1:0] g;
    logic       wen, fs, fd, ov;
    logic [7:0] oc;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          data;
  } wr_t;

  vec_t          tv [NV];
  wr_t           sb [$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [AW-1:0] last_addr = '0;
  int            exp_oc;
  logic          exp_ov;

  function automatic logic [AW-1:0] addr_of(input int i, input int c);
    return AW'(i * 65536 + (c % 65536));
  endfunction

  function automatic logic data_of(input int i, input int c);
    return 1'(((c / 3) + i) % 2);
  endfunction

  function automatic vec_t v(input logic sw, input logic [1:0] en, input logic [1:0] rq,
                             input logic [1:0] dn, input logic [1:0] we, input logic [1:0] g,
                             input logic wen, input logic fs, input logic fd, input logic ov,
                             input logic [7:0] oc);
    vec_t r;
    r.sw = sw; r.en = en; r.rq = rq; r.dn = dn; r.we = we;
    r.g = g; r.wen = wen; r.fs = fs; r.fd = fd; r.ov = ov; r.oc = oc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i);
    sb.push_back('{addr: addr_of(i, cyc), data: data_of(i, cyc)});
  endtask

  // Advance to the next falling edge, retire any visible write, refresh pixel inputs
  task automatic tick();
    wr_t w;
    @(negedge clk);
    cyc++;
    if (wr_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: wr_en=1 addr=%0h with no write pending (cycle %0d)",
                 wr_addr, cyc);
      end else begin
        w = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(w.addr));
        chk("wr_data", 32'(wr_data), 32'(w.data));
        last_addr = w.addr;
      end
    end
    for (int i = 0; i < N; i++) begin
      wr_addr_in[i*AW +: AW] = addr_of(i, cyc);
      wr_data_in[i]          = data_of(i, cyc);
    end
  endtask

  initial begin
    //        sw  en     rq     dn     we     | g      wen   fs    fd    ov    oc
    tv[0]  = v(1, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[1]  = v(0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    tv[2]  = v(0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[3]  = v(0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[4]  = v(0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[5]  = v(0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[6]  = v(0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[7]  = v(0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[8]  = v(1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[9]  = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    tv[10] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[11] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[12] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[13] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[14] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[15] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[16] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[17] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[18] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[19] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[20] = v(0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[21] = v(0, 2'b11, 2'b01, 2'b10, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[22] = v(0, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[23] = v(0, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[24] = v(0, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[25] = v(0, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[26] = v(0, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    tv[27] = v(1, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    tv[28] = v(0, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    tv[29] = v(0, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    tv[30] = v(0, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    tv[31] = v(0, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);

    rst = 1'b1; ce = 1'b1; swap = 1'b0; enable = '0; req = '0; done = '0;
    wr_en_in = '0; wr_addr_in = '0; wr_data_in = '0;
    repeat (2) tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_overrun_count", 32'(overrun_count), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      tick();
      chk($sformatf("grant[r%0d]", k), 32'(grant), 32'(tv[k].g));
      chk($sformatf("wr_en[r%0d]", k), 32'(wr_en), 32'(tv[k].wen));
      chk($sformatf("frame_start[r%0d]", k), 32'(frame_start), 32'(tv[k].fs));
      chk($sformatf("frame_done[r%0d]", k), 32'(frame_done), 32'(tv[k].fd));
      chk($sformatf("overrun[r%0d]", k), 32'(overrun), 32'(tv[k].ov));
      chk($sformatf("overrun_count[r%0d]", k), 32'(overrun_count), 32'(tv[k].oc));
      ce = 1'b1; swap = tv[k].sw; enable = tv[k].en; req = tv[k].rq;
      done = tv[k].dn; wr_en_in = tv[k].we;
      for (int i = 0; i < N; i++) begin
        if (tv[k].g[i] && tv[k].we[i]) push(i);
      end
    end

    // Repeated swap in GRANT: one overrun pulse per frame, count saturates
    tick();
    swap = 1'b1; enable = 2'b01; req = 2'b01; done = 2'b00; wr_en_in = 2'b00;
    exp_oc = 1; exp_ov = 1'b0;
    for (int n = 0; n < 300; n++) begin
      tick();
      chk("ovr_frame_start", 32'(frame_start), 32'd1);
      chk("ovr_pulse", 32'(overrun), 32'(exp_ov));
      chk("ovr_grant_dropped", 32'(grant), 32'd0);
      chk("ovr_count", 32'(overrun_count), 32'(exp_oc));
      swap = 1'b0;
      tick();
      chk("ovr_pulse_once", 32'(overrun), 32'd0);
      tick();
      chk("ovr_grant", 32'(grant), 32'd1);
      swap = 1'b1;
      exp_oc = (exp_oc == 255) ? 255 : exp_oc + 1;
      exp_ov = 1'b1;
    end
    tick();
    chk("ovr_last_pulse", 32'(overrun), 32'd1);
    chk("ovr_saturated", 32'(overrun_count), 32'd255);
    swap = 1'b0; wr_en_in = 2'b01;

    // ce low mid-burst freezes the burst; it resumes with two writes left
    tick();
    chk("ce_arb_grant", 32'(grant), 32'd0);
    tick();
    chk("ce_grant", 32'(grant), 32'd1);
    push(0);
    tick();
    chk("ce_w1", 32'(wr_en), 32'd1);
    push(0);
    tick();
    chk("ce_w2", 32'(wr_en), 32'd1);
    ce = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("ce_frozen_grant", 32'(grant), 32'd1);
      chk("ce_frozen_wr_en", 32'(wr_en), 32'd0);
    end
    chk("ce_addr_hold", 32'(wr_addr), 32'(last_addr));
    ce = 1'b1;
    push(0);
    tick();
    chk("ce_resume_grant", 32'(grant), 32'd1);
    chk("ce_resume_w3", 32'(wr_en), 32'd1);
    push(0);
    tick();
    chk("ce_burst_end", 32'(grant), 32'd0);
    chk("ce_resume_w4", 32'(wr_en), 32'd1);
    tick();
    chk("ce_regrant", 32'(grant), 32'd1);
    chk("ce_gap", 32'(wr_en), 32'd0);
    push(0);
    tick();
    chk("rst_pre_wr_en", 32'(wr_en), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_grant", 32'(grant), 32'd0);
    chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
    chk("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_mid_wr_data", 32'(wr_data), 32'd0);
    chk("rst_mid_overrun_count", 32'(overrun_count), 32'd0);
    rst = 1'b0; swap = 1'b1; enable = 2'b11; req = 2'b11; wr_en_in = 2'b00;

    // After reset requester 0 has first priority
    tick();
    chk("post_rst_frame_start", 32'(frame_start), 32'd1);
    swap = 1'b0;
    tick();
    chk("post_rst_arb", 32'(grant), 32'd0);
    tick();
    chk("post_rst_first_grant", 32'(grant), 32'd1);
    req = 2'b00;
    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
